// File: rtl/pwm_level_ramp.sv
// pwm_level_ramp: per-channel slew-rate limiter between the SPI command
// decoder and the PWM comparator bank. Targets arrive over a valid/ready
// write port. Each current level walks toward its target by at most STEP
// once every PRESCALE clocks.
// Optional feature macro: PWM_RAMP_FAST_OFF_EN. When it is defined, a write
// of 0 also zeroes the channel's current level at once (emergency stop).
module pwm_level_ramp #(
    parameter int NUM_CH   = 3,
    parameter int WIDTH    = 8,
    parameter int STEP     = 16,
    parameter int PRESCALE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [2:0]              wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    output logic                    wr_err,
    output logic [NUM_CH*WIDTH-1:0] level_out,
    output logic [NUM_CH-1:0]       busy,
    output logic                    settle
);

    localparam int                CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]  STEP_U   = WIDTH'(STEP);
    localparam logic signed [WIDTH:0] STEP_S = (WIDTH + 1)'(STEP);

    logic [CW-1:0]       cnt_r;
    logic                wr_ready_r;
    logic                wr_err_r;
    logic                settle_r;
    logic [NUM_CH-1:0]   busy_r;
    logic [WIDTH-1:0]    cur_r [NUM_CH];
    logic [WIDTH-1:0]    tgt_r [NUM_CH];

    logic                tick_s;
    logic                accept_s;
    logic                addr_ok_s;
    logic signed [WIDTH:0] diff_s [NUM_CH];
    logic [WIDTH-1:0]    ramp_s [NUM_CH];
    logic [WIDTH-1:0]    cur_nxt_s [NUM_CH];
    logic [NUM_CH-1:0]   fast_off_s;
    logic [NUM_CH-1:0]   reach_s;
    logic [NUM_CH-1:0]   sel_s;

    assign tick_s    = (cnt_r == CNT_LAST);
    assign accept_s  = wr_valid & wr_ready_r;
    assign addr_ok_s = (wr_addr < 3'(NUM_CH));

    // Per-channel ramp step, channel select, emergency stop and settle detect.
    always_comb begin
        fast_off_s = '0;
        reach_s    = '0;
        sel_s      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            diff_s[i]    = $signed({1'b0, tgt_r[i]}) - $signed({1'b0, cur_r[i]});
            ramp_s[i]    = tgt_r[i];
            cur_nxt_s[i] = cur_r[i];
            sel_s[i]     = accept_s && addr_ok_s && (wr_addr == 3'(i));
            // The far side of the comparison guarantees cur +/- STEP stays inside the range.
            if (diff_s[i] > STEP_S) begin
                ramp_s[i] = cur_r[i] + STEP_U;
            end else if (diff_s[i] < -STEP_S) begin
                ramp_s[i] = cur_r[i] - STEP_U;
            end else begin
                ramp_s[i] = tgt_r[i];
            end
`ifdef PWM_RAMP_FAST_OFF_EN
            fast_off_s[i] = sel_s[i] && (wr_data == '0);
`else
            fast_off_s[i] = 1'b0;
`endif
            if (fast_off_s[i]) begin
                cur_nxt_s[i] = '0;
            end else if (tick_s) begin
                cur_nxt_s[i] = ramp_s[i];
            end else begin
                cur_nxt_s[i] = cur_r[i];
            end
            // The tick sees the old target, so reaching it counts even if a write lands now.
            reach_s[i] = tick_s && !fast_off_s[i] && (cur_r[i] != tgt_r[i]) && (ramp_s[i] == tgt_r[i]);
        end
    end

    // Prescaler that free-runs 0..PRESCALE-1 and produces the ramp tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Write handshake: one write per two clocks, error pulse for bad addresses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ready_r <= 1'b1;
            wr_err_r   <= 1'b0;
        end else begin
            wr_ready_r <= ~accept_s;
            wr_err_r   <= accept_s & ~addr_ok_s;
        end
    end

    // Target and current level registers for every channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_r[i] <= '0;
                cur_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cur_r[i] <= cur_nxt_s[i];
                if (sel_s[i]) begin
                    tgt_r[i] <= wr_data;
                end else begin
                    tgt_r[i] <= tgt_r[i];
                end
            end
        end
    end

    // Registered status: busy follows current != target, settle marks a completed ramp.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r   <= '0;
            settle_r <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                busy_r[i] <= (cur_r[i] != tgt_r[i]);
            end
            settle_r <= |reach_s;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_level
        assign level_out[g*WIDTH +: WIDTH] = cur_r[g];
    end

    assign wr_ready = wr_ready_r;
    assign wr_err   = wr_err_r;
    assign busy     = busy_r;
    assign settle   = settle_r;

endmodule
